// File: rtl/pci_target_mem.sv
// PCI-style bus target: claims an address window and services single/burst reads and writes
// into a word memory. Define PCI_PARITY_EN to enable par generation/checking and perr.
module pci_target_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          MEM_DEPTH   = 10,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iframe,
  input  logic        iready,
  input  logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  inout  wire         tready,
  inout  wire         devsel,
  inout  wire         par,
  output logic        perr,
  output logic [15:0] xfer_count,
  output logic        busy
);

  localparam int                IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MEM_DEPTH - 1);
  localparam logic [31:0]       WIN_BYTES = 32'(4 * MEM_DEPTH);
  localparam logic [2:0]        WAIT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, DATA, TURN} state_t;

  state_t           state, state_nxt;
  logic [2:0]       wait_cnt;
  logic [IDX_W-1:0] idx;
  logic             rw_wr;
  logic             any_xfer;
  logic             iframe_p1;
  logic [31:0]      mem [MEM_DEPTH];

  logic             bus_oe, devsel_val, tready_val, ad_oe;
  logic [31:0]      ad_off;
  logic             addr_phase, cmd_ok, in_window, hit, xfer;
  logic [31:0]      rd_word;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Address decode: a falling iframe edge is the only address phase.
  assign ad_off     = AD - BASE_ADDR;
  assign addr_phase = !iframe && iframe_p1;
  assign cmd_ok     = (CBE == 4'b0000) || (CBE == 4'b1000);
  assign in_window  = (AD >= BASE_ADDR) && (ad_off < WIN_BYTES);
  assign hit        = addr_phase && cmd_ok && in_window;
  assign xfer       = (state == DATA) && !iready;
  assign rd_word    = mem[idx];
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    bus_oe     = 1'b0;
    devsel_val = 1'b1;
    tready_val = 1'b1;
    ad_oe      = 1'b0;
    case (state)
      IDLE: begin
        if (hit) state_nxt = (WAIT_STATES > 0) ? WAIT : DATA;
      end
      WAIT: begin
        bus_oe     = 1'b1;
        devsel_val = 1'b0;
        ad_oe      = !rw_wr;
        if (wait_cnt == 3'd0) state_nxt = DATA;
      end
      DATA: begin
        bus_oe     = 1'b1;
        devsel_val = 1'b0;
        tready_val = 1'b0;
        ad_oe      = !rw_wr;
        // Last data phase completes, or the initiator walks away before any transfer.
        if (iframe && (xfer || !any_xfer)) state_nxt = TURN;
      end
      TURN: begin
        bus_oe    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      iframe_p1  <= 1'b1;
      wait_cnt   <= 3'd0;
      idx        <= '0;
      rw_wr      <= 1'b0;
      any_xfer   <= 1'b0;
      xfer_count <= 16'd0;
    end else begin
      state     <= state_nxt;
      iframe_p1 <= iframe;
      if (state == IDLE && hit) begin
        idx      <= ad_off[IDX_W+1:2];
        rw_wr    <= CBE[3];
        any_xfer <= 1'b0;
        wait_cnt <= WAIT_LOAD;
      end
      if (state == WAIT && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
      if (xfer) begin
        idx        <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        any_xfer   <= 1'b1;
        xfer_count <= sat_inc(xfer_count);
      end
    end
  end

  // Memory write port: byte lanes gated by the data-phase byte enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (xfer && rw_wr) begin
      for (int b = 0; b < 4; b++)
        if (CBE[b]) mem[idx][8*b +: 8] <= AD[8*b +: 8];
    end
  end

  assign devsel = bus_oe ? devsel_val : 1'bz;
  assign tready = bus_oe ? tready_val : 1'bz;
  assign AD     = ad_oe  ? rd_word    : 32'bz;

`ifdef PCI_PARITY_EN
  logic par_oe_p1, chk_vld_p1, perr_p1;
  logic par_val_p1, chk_exp_p1;

  // Parity stage: one cycle behind the data word it covers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_oe_p1  <= 1'b0;
      chk_vld_p1 <= 1'b0;
      perr_p1    <= 1'b1;
    end else begin
      par_oe_p1  <= ad_oe;
      chk_vld_p1 <= xfer && rw_wr;
      perr_p1    <= !(chk_vld_p1 && (par != chk_exp_p1));
    end
  end

  always_ff @(posedge clk) begin
    par_val_p1 <= ^{rd_word, CBE};
    chk_exp_p1 <= ^{AD, CBE};
  end

  assign par  = (par_oe_p1 && (state == WAIT || state == DATA)) ? par_val_p1 : 1'bz;
  assign perr = perr_p1;
`else
  assign par  = 1'bz;
  assign perr = 1'b1;
`endif

endmodule

// File: tb/tb_pci_target_mem.sv
// Randomized self-checking bench for pci_target_mem against an array-based memory model.
module tb_pci_target_mem;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 10;
  localparam int          WS    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iframe = 1'b1;
  logic        iready = 1'b1;
  logic [3:0]  cbe = 4'h0;
  logic [31:0] tb_ad = 32'h0;
  logic        tb_ad_oe = 1'b0;
  wire  [31:0] AD;
  wire         tready, devsel, par;
  logic        perr;
  logic [15:0] xfer_count;
  logic        busy;

  assign AD = tb_ad_oe ? tb_ad : 32'bz;
  pullup (tready);
  pullup (devsel);

  pci_target_mem #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .iframe(iframe), .iready(iready), .CBE(cbe), .AD(AD),
    .tready(tready), .devsel(devsel), .par(par), .perr(perr),
    .xfer_count(xfer_count), .busy(busy));

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  logic [31:0] mem_m [DEPTH];
  int          cnt_m;

  logic [31:0] wdat [16];
  logic [3:0]  wbe  [16];
  logic [31:0] rdat [16];
  logic [31:0] stall_ads [$];
  int          dev_lat, trdy_lat;
  logic        timed_out, turn_dev, turn_trdy, turn_busy;

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) mem_m[k] = 32'h0;
    cnt_m = 0;
  endtask

  task automatic model_apply(input logic wr, input int start, input int n);
    for (int k = 0; k < n; k++) begin
      if (wr)
        for (int b = 0; b < 4; b++)
          if (wbe[k][b]) mem_m[(start + k) % DEPTH][8*b +: 8] = wdat[k][8*b +: 8];
    end
    cnt_m = (cnt_m + n > 65535) ? 65535 : cnt_m + n;
  endtask

  // Initiator: address phase, n data phases (optional stall), returns at the negedge after the
  // last transfer (target in turnaround) or right after transfer number abort_after.
  task automatic bus_txn(input logic wr, input int start, input int n,
                         input int stall_at, input int stall_len, input int abort_after);
    int i, stall_cnt;
    logic xfer, stall_now;
    i = 0; stall_cnt = 0; dev_lat = -1; trdy_lat = -1;
    stall_ads.delete();
    iframe = 1'b0; iready = 1'b1; cbe = wr ? 4'b1000 : 4'b0000;
    tb_ad = BASE + 32'(start * 4); tb_ad_oe = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc < 80; cyc++) begin
      if (i == n) break;
      stall_now = (i == stall_at) && (stall_cnt < stall_len);
      if (stall_now) stall_cnt++;
      iframe = (i == n - 1); iready = stall_now; cbe = wr ? wbe[i] : 4'hF;
      tb_ad = wdat[i]; tb_ad_oe = wr;
      if (dev_lat < 0 && devsel === 1'b0) dev_lat = cyc;
      if (trdy_lat < 0 && tready === 1'b0) trdy_lat = cyc;
      xfer = (tready === 1'b0) && !stall_now;
      if (xfer && !wr) rdat[i] = AD;
      if (tready === 1'b0 && stall_now) stall_ads.push_back(AD);
      @(negedge clk);
      if (xfer) i++;
      if (i == abort_after) return;
    end
    timed_out = (i != n);
    iframe = 1'b1; iready = 1'b1; tb_ad_oe = 1'b0; cbe = 4'h0;
    turn_dev = devsel; turn_trdy = tready; turn_busy = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_run++; if (xfer_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", xfer_count); end
    n_run++; if (perr !== 1'b1) begin n_fail++; $display("FAIL reset_perr: got %b want 1", perr); end
    n_run++; if ({devsel, tready} !== 2'b11) begin n_fail++; $display("FAIL reset_bus_released: got %b want 11", {devsel, tready}); end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    bus_txn(1'b0, 0, DEPTH, -1, 0, -1);
    model_apply(1'b0, 0, DEPTH);
    n_run++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL reset_read_timeout: got %b want 0", timed_out); end
    for (int k = 0; k < DEPTH; k++) begin
      n_run++; if (rdat[k] !== mem_m[k]) begin n_fail++; $display("FAIL reset_mem[%0d]: got %h want %h", k, rdat[k], mem_m[k]); end
    end
    @(negedge clk);
  endtask

  task automatic test_single_write();
    wdat[0] = 32'hDEAD_BEEF; wbe[0] = 4'hF;
    bus_txn(1'b1, 0, 1, -1, 0, -1);
    model_apply(1'b1, 0, 1);
    n_run++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b want 0", timed_out); end
    n_run++; if (dev_lat !== 1) begin n_fail++; $display("FAIL single_devsel_latency: got %0d want 1", dev_lat); end
    n_run++; if (trdy_lat !== 1 + WS) begin n_fail++; $display("FAIL single_tready_latency: got %0d want %0d", trdy_lat, 1 + WS); end
    n_run++; if ({turn_dev, turn_trdy, turn_busy} !== 3'b111) begin n_fail++; $display("FAIL single_turnaround: got %b want 111", {turn_dev, turn_trdy, turn_busy}); end
    n_run++; if (xfer_count !== 16'(cnt_m)) begin n_fail++; $display("FAIL single_count: got %0d want %0d", xfer_count, cnt_m); end
    @(negedge clk);
    n_run++; if ({busy, devsel, tready} !== 3'b011) begin n_fail++; $display("FAIL single_release: got %b want 011", {busy, devsel, tready}); end
    bus_txn(1'b0, 0, 1, -1, 0, -1);
    model_apply(1'b0, 0, 1);
    n_run++; if (rdat[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_readback: got %h want deadbeef", rdat[0]); end
    @(negedge clk);
  endtask

  task automatic test_byte_enable();
    wdat[0] = 32'hFFFF_FFFF; wbe[0] = 4'hF;
    bus_txn(1'b1, 2, 1, -1, 0, -1); model_apply(1'b1, 2, 1); @(negedge clk);
    wdat[0] = 32'h1122_3344; wbe[0] = 4'b0101;
    bus_txn(1'b1, 2, 1, -1, 0, -1); model_apply(1'b1, 2, 1); @(negedge clk);
    bus_txn(1'b0, 2, 1, -1, 0, -1); model_apply(1'b0, 2, 1);
    n_run++; if (rdat[0] !== mem_m[2]) begin n_fail++; $display("FAIL byte_enable: got %h want %h", rdat[0], mem_m[2]); end
    @(negedge clk);
  endtask

  task automatic test_wrap_read();
    int c0;
    for (int k = 0; k < 4; k++) begin wdat[k] = $urandom; wbe[k] = 4'hF; end
    bus_txn(1'b1, 8, 4, -1, 0, -1); model_apply(1'b1, 8, 4); @(negedge clk);
    c0 = cnt_m;
    bus_txn(1'b0, 8, 4, -1, 0, -1); model_apply(1'b0, 8, 4);
    n_run++; if (trdy_lat !== 1 + WS) begin n_fail++; $display("FAIL wrap_tready_latency: got %0d want %0d", trdy_lat, 1 + WS); end
    for (int k = 0; k < 4; k++) begin
      n_run++; if (rdat[k] !== mem_m[(8 + k) % DEPTH]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", k, rdat[k], mem_m[(8 + k) % DEPTH]); end
    end
    n_run++; if (xfer_count !== 16'(c0 + 4)) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", xfer_count, c0 + 4); end
    @(negedge clk);
  endtask

  task automatic test_miss();
    logic [31:0] addrs [4];
    logic [3:0]  cmds [4];
    int bad;
    addrs[0] = 32'h0000_0200;           cmds[0] = 4'b0000;
    addrs[1] = BASE;                    cmds[1] = 4'b0110;
    addrs[2] = BASE - 32'd4;            cmds[2] = 4'b0000;
    addrs[3] = BASE + 32'(4 * DEPTH);   cmds[3] = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      bad = 0;
      iframe = 1'b0; iready = 1'b1; tb_ad = addrs[c]; tb_ad_oe = 1'b1; cbe = cmds[c];
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        iready = 1'b0; cbe = 4'hF;
        if ({busy, devsel, tready} !== 3'b011) bad++;
      end
      n_run++; if (bad != 0) begin n_fail++; $display("FAIL miss_%0d: got %0d claimed cycles want 0", c, bad); end
      iframe = 1'b1; iready = 1'b1; tb_ad_oe = 1'b0; cbe = 4'h0;
      @(negedge clk);
    end
    n_run++; if (xfer_count !== 16'(cnt_m)) begin n_fail++; $display("FAIL miss_count: got %0d want %0d", xfer_count, cnt_m); end
  endtask

  task automatic test_stall();
    int c0;
    c0 = cnt_m;
    bus_txn(1'b0, 3, 4, 2, 2, -1); model_apply(1'b0, 3, 4);
    n_run++; if (stall_ads.size() !== 2) begin n_fail++; $display("FAIL stall_cycles: got %0d want 2", stall_ads.size()); end
    foreach (stall_ads[k]) begin
      n_run++; if (stall_ads[k] !== mem_m[5]) begin n_fail++; $display("FAIL stall_ad_hold[%0d]: got %h want %h", k, stall_ads[k], mem_m[5]); end
    end
    for (int k = 0; k < 4; k++) begin
      n_run++; if (rdat[k] !== mem_m[3 + k]) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", k, rdat[k], mem_m[3 + k]); end
    end
    n_run++; if (xfer_count !== 16'(c0 + 4)) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", xfer_count, c0 + 4); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    wdat[0] = $urandom; wbe[0] = 4'hF;
    bus_txn(1'b1, 4, 1, -1, 0, -1); model_apply(1'b1, 4, 1);
    iframe = 1'b0; iready = 1'b0; tb_ad = BASE + 32'd16; tb_ad_oe = 1'b1; cbe = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tb_ad_oe = 1'b0; cbe = 4'hF;
      if ({busy, devsel} !== 2'b01) bad++;
    end
    n_run++; if (bad != 0) begin n_fail++; $display("FAIL b2b_ignored: got %0d claimed cycles want 0", bad); end
    iframe = 1'b1; iready = 1'b1;
    @(negedge clk);
    bus_txn(1'b0, 4, 1, -1, 0, -1); model_apply(1'b0, 4, 1);
    n_run++; if (rdat[0] !== mem_m[4]) begin n_fail++; $display("FAIL b2b_readback: got %h want %h", rdat[0], mem_m[4]); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic wr;
    int start, n, sat, sln;
    for (int t = 0; t < 12; t++) begin
      wr = 1'($urandom_range(0, 1)); start = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 6); sat = $urandom_range(1, 6); sln = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin wdat[k] = $urandom; wbe[k] = 4'($urandom_range(0, 15)); end
      bus_txn(wr, start, n, sat, sln, -1); model_apply(wr, start, n);
      n_run++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout: got %b want 0", t, timed_out); end
      n_run++; if (xfer_count !== 16'(cnt_m)) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", t, xfer_count, cnt_m); end
      if (!wr)
        for (int k = 0; k < n; k++) begin
          n_run++; if (rdat[k] !== mem_m[(start + k) % DEPTH]) begin n_fail++; $display("FAIL rand%0d_data[%0d]: got %h want %h", t, k, rdat[k], mem_m[(start + k) % DEPTH]); end
        end
      @(negedge clk);
    end
    bus_txn(1'b0, 0, DEPTH, -1, 0, -1); model_apply(1'b0, 0, DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      n_run++; if (rdat[k] !== mem_m[k]) begin n_fail++; $display("FAIL rand_final_mem[%0d]: got %h want %h", k, rdat[k], mem_m[k]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    for (int k = 0; k < 4; k++) begin wdat[k] = $urandom | 32'h1; wbe[k] = 4'hF; end
    bus_txn(1'b1, 0, 4, -1, 0, 2);
    rst_n = 1'b0;
    #1;
    n_run++; if ({busy, devsel, tready} !== 3'b011) begin n_fail++; $display("FAIL rstmid_release: got %b want 011", {busy, devsel, tready}); end
    n_run++; if (xfer_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", xfer_count); end
    iframe = 1'b1; iready = 1'b1; tb_ad_oe = 1'b0; cbe = 4'h0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_txn(1'b0, 0, DEPTH, -1, 0, -1); model_apply(1'b0, 0, DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      n_run++; if (rdat[k] !== mem_m[k]) begin n_fail++; $display("FAIL rstmid_mem[%0d]: got %h want %h", k, rdat[k], mem_m[k]); end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_write();
    test_byte_enable();
    test_wrap_read();
    test_miss();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pci_target_mem.md
Name: pci_target_mem

Overview:
- Parametrised PCI-style bus target: decodes an address window, claims the transaction with devsel, and services single and burst reads/writes into an internal word memory.
- Features: byte-enable masking, programmable initial wait states, wrap-around burst addressing, proper end-of-transaction turnaround.
- Sits on the shared iframe/AD/CBE/iready/tready/devsel bus next to the arbiter-driven initiator devices.

Parameters:
- BASE_ADDR, 32'h0000_0100, byte address of memory word 0; must be 4-byte aligned.
- MEM_DEPTH, 10, number of 32-bit words (2..256).
- WAIT_STATES, 0, cycles between devsel assertion and first tready assertion (0..7).

Ports:
- clk  input  1  bus clock; all sampling and driving on posedge.
- rst_n  input  1  asynchronous active-low reset.
- iframe  input  1  initiator frame, active low.
- iready  input  1  initiator ready, active low.
- CBE  input  4  command in address phase; byte enables (active high) in data phase.
- AD  inout  32  multiplexed address/data; driven only during read data phases.
- tready  inout  1  target ready, active low; Z when not claimed.
- devsel  inout  1  device select, active low; Z when not claimed.
- par  inout  1  even parity over AD+CBE (see optional feature).
- perr  output  1  parity error flag, active low.
- xfer_count  output  16  completed data transfers since reset, saturating at 16'hFFFF.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; tready/devsel/AD/par drive enables off (Z).
  - perr=1, xfer_count=0, busy=0.
  - Memory cleared to 0.
  - Reset mid-transaction releases the bus immediately; no partial write completes.
- Address phase: posedge where iframe=0 and iframe was 1 at the previous posedge.
  - Hit when BASE_ADDR <= AD < BASE_ADDR+4*MEM_DEPTH and CBE is 4'b0000 (read) or 4'b1000 (write).
  - On hit: latch idx=(AD-BASE_ADDR)>>2 and rw; miss or other command leaves the target in IDLE.
- States:
  - IDLE -> WAIT (WAIT_STATES>0) or DATA on hit. devsel drives 0 from the cycle after the address phase.
  - WAIT: countdown of WAIT_STATES cycles with devsel=0, tready=1, then go to DATA with tready=0.
  - DATA: tready=0. A transfer occurs at each posedge with iready=0 and tready=0.
    - Write: memory[idx] byte lanes updated where CBE[i]=1.
    - Read: AD driven with memory[idx] from the first post-address cycle (turnaround); on transfer, AD updates to the next word in the same edge.
    - Each transfer increments idx and xfer_count.
  - Wrap: idx=MEM_DEPTH-1 with a transfer and iframe still 0 -> idx=0.
  - TURN: entered after a transfer sampled with iframe=1 (last data phase), or with iframe=1 and iready=1 before any transfer (initiator abandon). Drives devsel=1, tready=1 and stops driving AD for one cycle, then releases all to Z -> IDLE.
- iready=1 in DATA: wait; hold state, idx and AD.
- Transfers sampled during WAIT are ignored (tready=1).
- Back-to-back: an address phase sampled in TURN is ignored; a new transaction requires iframe high for at least one cycle.

Optional Feature:
- PCI_PARITY_EN defined:
  - Reads: par driven one cycle after each AD data word with even parity of {AD,CBE}.
  - Writes: target samples par one cycle after each data transfer; on mismatch, perr=0 for exactly one cycle and the memory write still commits.
  - par is released to Z in TURN.
- Undefined: par never driven (Z), perr held 1, no parity logic synthesised.

Test Plan:
- WAIT_STATES=0, write 32'hDEAD_BEEF to 32'h0000_0100 with CBE=4'hF, single phase -> devsel low 1 cycle after address phase; memory[0]=DEAD_BEEF; xfer_count=1; devsel/tready high one cycle then Z.
- Write 32'h1122_3344 with CBE=4'b0101 over memory[2]=32'hFFFF_FFFF -> memory[2]=32'hFF22_FF44.
- WAIT_STATES=3, 4-word read burst starting at word 8 (MEM_DEPTH=10) -> tready low 3 cycles after devsel; AD returns words 8,9,0,1; xfer_count +4.
- Address 32'h0000_0200 or CBE=4'b0110 -> devsel and tready stay Z; busy stays 0.
- iready held high 2 cycles mid read burst -> AD and idx held; no xfer_count increment.
- Reset during a write burst after 2 transfers -> outputs Z immediately, xfer_count=0, memory all zero. With PCI_PARITY_EN, a corrupted par on a write -> perr=0 for one cycle.
